alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU.
- Adds WIDTH generalisation, an iterative shift-add multiplier, registered outputs and a start/busy/done handshake.
- Sits in the execute stage of the multi-cycle processor; the controller launches an op and waits on done before writeback.
- Flags follow the NZCV convention used by the condition-check logic.

---
 rtl/alu_mc.sv | 182 ++++++++++++++++++
 tb/tb_alu_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU with shift-add multiplier and start/busy/done handshake.
// Optional barrel shifter (LSL/LSR/ASR) enabled by defining ALU_MC_SHIFT_EN.
module alu_mc #(
    parameter  int WIDTH = 32,
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
`ifdef ALU_MC_SHIFT_EN
    localparam logic [3:0] OP_LSL = 4'b0110;
    localparam logic [3:0] OP_LSR = 4'b0111;
    localparam logic [3:0] OP_ASR = 4'b1000;
`endif

    localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;

    logic              sub;
    logic [WIDTH-1:0]  bx;
    logic [WIDTH:0]    sum;
    logic [WIDTH-1:0]  res_c;
    logic              c_c;
    logic              v_c;
    logic [WIDTH-1:0]  acc_next;

`ifdef ALU_MC_SHIFT_EN
    logic [CNTW-2:0]     amt;
    logic [WIDTH:0]      lsl_t;
    logic [WIDTH:0]      lsr_t;
    logic signed [WIDTH:0] asr_t;
`endif

    // Single-cycle datapath, evaluated from the captured operands.
    always_comb begin
        res_c = '0;
        c_c   = 1'b0;
        v_c   = 1'b0;
        sub   = (op_q == OP_SUB);
        bx    = sub ? ~b_q : b_q;
        sum   = {1'b0, a_q} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
`ifdef ALU_MC_SHIFT_EN
        amt   = b_q[CNTW-2:0];
        lsl_t = {1'b0, a_q} << amt;
        lsr_t = {a_q, 1'b0} >> amt;
        asr_t = $signed({a_q, 1'b0}) >>> amt;
`endif
        case (op_q)
            OP_ADD, OP_SUB: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = ~(a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sub)
                      & (a_q[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND: res_c = a_q & b_q;
            OP_OR:  res_c = a_q | b_q;
            OP_XOR: res_c = a_q ^ b_q;
`ifdef ALU_MC_SHIFT_EN
            OP_LSL: begin
                res_c = lsl_t[WIDTH-1:0];
                c_c   = lsl_t[WIDTH];
            end
            OP_LSR: begin
                res_c = lsr_t[WIDTH:1];
                c_c   = lsr_t[0];
            end
            OP_ASR: begin
                res_c = asr_t[WIDTH:1];
                c_c   = asr_t[0];
            end
`endif
            default: res_c = '0;
        endcase
    end

    assign acc_next = acc_q + (b_q[0] ? a_q : '0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle still belongs to the previous op.
                if (start && !done_q) begin
                    op_d    = ALUControl;
                    a_d     = SrcA;
                    b_d     = SrcB;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op_q == OP_MUL) begin
                    acc_d = acc_next;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == LAST) begin
                        result_d = acc_next;
                        flags_d  = {acc_next[WIDTH-1],
                                    acc_next == '0, 2'b00};
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    result_d = res_c;
                    flags_d  = {res_c[WIDTH-1], res_c == '0, c_c, v_c};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    assign Result   = result_q;
    assign ALUFlags = flags_q;
    assign busy     = (state_q == EXEC);
    assign done     = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: 32-bit and 8-bit instances, vector table
// plus handshake, reset-abort and back-to-back sequences.
module tb_alu_mc;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        start8;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;

    logic [31:0] res;
    logic [3:0]  flg;
    logic        busy;
    logic        done;

    logic [7:0]  res8;
    logic [3:0]  flg8;
    logic        busy8;
    logic        done8;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .SrcA       (a),
        .SrcB       (b),
        .ALUControl (op),
        .Result     (res),
        .ALUFlags   (flg),
        .busy       (busy),
        .done       (done)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .SrcA       (a[7:0]),
        .SrcB       (b[7:0]),
        .ALUControl (op),
        .Result     (res8),
        .ALUFlags   (flg8),
        .busy       (busy8),
        .done       (done8)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        bit          w8;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic add(input string nm, input bit w8, input logic [3:0] o,
                       input logic [31:0] sa, input logic [31:0] sb,
                       input logic [31:0] r, input logic [3:0] f,
                       input int lat);
        vec_t v;
        v.nm = nm; v.w8 = w8; v.op = o; v.a = sa; v.b = sb;
        v.r = r; v.f = f; v.lat = lat;
        vt.push_back(v);
    endtask

    // Launch one op and wait (bounded) for done; prev is the value the
    // bench expects Result to hold until done.
    task automatic run_op(input bit w8, input logic [3:0] o,
                          input logic [31:0] sa, input logic [31:0] sb,
                          input logic [31:0] prev,
                          output logic [31:0] r, output logic [3:0] f,
                          output int lat, output bit stable,
                          output bit busy_ok);
        @(negedge clk);
        op = o; a = sa; b = sb;
        if (w8) start8 = 1'b1;
        else    start  = 1'b1;
        @(negedge clk);
        start = 1'b0; start8 = 1'b0;
        lat = 1; stable = 1'b1;
        busy_ok = w8 ? busy8 : busy;
        while (!(w8 ? done8 : done) && lat < 200) begin
            if ((w8 ? {24'b0, res8} : res) !== prev) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        r = w8 ? {24'b0, res8} : res;
        f = w8 ? flg8 : flg;
        busy_ok = busy_ok & !(w8 ? busy8 : busy);
    endtask

    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    bit          stable;
    bit          bok;
    logic [31:0] prev32;
    logic [31:0] prev8;
    int          ndone;

    initial begin
        reset = 1'b1; start = 1'b1; start8 = 1'b1;
        op = 4'b0000; a = 32'h1; b = 32'h1;

        add("add_ovf", 0, 4'b0000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b1001, 2);
        add("sub_eq", 0, 4'b0001, 32'h5, 32'h5, 32'h0, 4'b0110, 2);
        add("and", 0, 4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000, 2);
        add("or", 0, 4'b0011, 32'h0000000F, 32'h000000F0, 32'h000000FF, 4'b0000, 2);
        add("xor", 0, 4'b0100, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h0F0F0F0F, 4'b0000, 2);
        add("mul", 0, 4'b0101, 32'h00010001, 32'h00010001, 32'h00020001, 4'b0000, 33);
        add("add_carry", 0, 4'b0000, 32'hFFFFFFFF, 32'h1, 32'h0, 4'b0110, 2);
        add("sub_borrow", 0, 4'b0001, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b1000, 2);
        add("sub_ovf", 0, 4'b0001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 4'b0011, 2);
        add("illegal", 0, 4'b1111, 32'h12345678, 32'h9, 32'h0, 4'b0100, 2);
        add("mul_ones", 0, 4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0000, 33);
`ifdef ALU_MC_SHIFT_EN
        add("lsl", 0, 4'b0110, 32'h80000001, 32'h1, 32'h2, 4'b0010, 2);
        add("asr", 0, 4'b1000, 32'h80000000, 32'h4, 32'hF8000000, 4'b1000, 2);
`else
        add("lsl_off", 0, 4'b0110, 32'h80000001, 32'h1, 32'h0, 4'b0100, 2);
        add("asr_off", 0, 4'b1000, 32'h80000000, 32'h4, 32'h0, 4'b0100, 2);
`endif
        add("lsr_big", 0, 4'b0111, 32'h0000007F, 32'd40, 32'h0, 4'b0100, 2);
        add("w8_mul", 1, 4'b0101, 32'h10, 32'h10, 32'h0, 4'b0100, 9);
        add("w8_add", 1, 4'b0000, 32'hFF, 32'h01, 32'h0, 4'b0110, 2);
        add("w8_sub", 1, 4'b0001, 32'h80, 32'h01, 32'h7F, 4'b0011, 2);

        // Reset held with start high: nothing may happen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst res", res, 32'h0);
            chk("rst flags/busy/done", {flg, busy, done}, 6'b0);
        end
        reset = 1'b0; start = 1'b0; start8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("idle busy/done", {busy, done, busy8, done8}, 4'b0);
        end

        prev32 = 32'h0;
        prev8  = 32'h0;
        foreach (vt[i]) begin
            run_op(vt[i].w8, vt[i].op, vt[i].a, vt[i].b,
                   vt[i].w8 ? prev8 : prev32, r, f, lat, stable, bok);
            chk({vt[i].nm, " res"}, r, vt[i].r);
            chk({vt[i].nm, " flags"}, {28'b0, f}, {28'b0, vt[i].f});
            chk({vt[i].nm, " latency"}, lat, vt[i].lat);
            chk({vt[i].nm, " busy"}, {31'b0, bok}, 32'h1);
            chk({vt[i].nm, " stable"}, {31'b0, stable}, 32'h1);
            if (vt[i].w8) prev8 = vt[i].r;
            else          prev32 = vt[i].r;
        end

        // MUL with a stray start while busy.
        @(negedge clk);
        op = 4'b0101; a = 32'h00010001; b = 32'h00010001; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 200) begin
            start = (lat == 10);
            if (lat == 10) begin
                op = 4'b0000; a = 32'h1; b = 32'h1;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk("mul_ign latency", lat, 33);
        chk("mul_ign res", res, 32'h00020001);
        chk("mul_ign flags", {28'b0, flg}, 32'h0);
        @(negedge clk);
        chk("mul_ign no restart", {busy, done}, 2'b00);

        // Reset in the middle of a second MUL aborts it.
        op = 4'b0101; a = 32'h3; b = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("mul_abort busy before", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mul_abort res", res, 32'h0);
        chk("mul_abort flags/busy/done", {flg, busy, done}, 6'b0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mul_abort no done", ndone, 0);

        // Back-to-back: start during done is dropped, next cycle accepted.
        @(negedge clk);
        op = 4'b0000; a = 32'h1; b = 32'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b first res", res, 32'h3);
        op = 4'b0100; a = 32'hF0F0F0F0; b = 32'hFFFFFFFF; start = 1'b1;
        @(negedge clk);
        chk("b2b start on done ignored", {busy, done}, 2'b00);
        @(negedge clk);
        start = 1'b0;
        chk("b2b start accepted", {busy, done}, 2'b10);
        @(negedge clk);
        chk("b2b done", {busy, done}, 2'b01);
        chk("b2b res", res, 32'h0F0F0F0F);
        chk("b2b flags", {28'b0, flg}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
